// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, memory-stage and memory-port signals around mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              i_req;
    logic [AWIDTH-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DWIDTH-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [1:0]        d_size;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DWIDTH-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [AWIDTH-1:0] m_addr;
    logic [1:0]        m_size;
    logic [DWIDTH-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DWIDTH-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_size, d_wdata,
        input  m_ready, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_size, m_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_size, d_wdata,
        output m_ready, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_size, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / memory-stage arbiter onto one memory port, one transaction in flight.
// Define MEM_ARB_FAIR_EN to promote fetch after STARVE_LIMIT denied cycles.
module mem_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        HOLD_I,
        HOLD_D,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_sel_i;
    logic   w_sel_d;
    logic   w_fetch_pri;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be >= 1");
    end

`ifdef MEM_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (bus.i_gnt) begin
            r_starve <= '0;
        end else if (bus.i_req && (r_starve < CW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_fetch_pri = bus.i_req && (r_starve >= CW'(STARVE_LIMIT));
`else
    assign w_fetch_pri = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sel_i      = 1'b0;
        w_sel_d      = 1'b0;
        bus.m_req    = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_addr   = {AWIDTH{1'b0}};
        bus.m_size   = 2'd0;
        bus.m_wdata  = {DWIDTH{1'b0}};
        bus.i_gnt    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.i_rdata  = {DWIDTH{1'b0}};
        bus.d_rdata  = {DWIDTH{1'b0}};

        // Outputs held quiet while reset is asserted, even in IDLE.
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    w_sel_d = bus.d_req && !w_fetch_pri;
                    w_sel_i = bus.i_req && !w_sel_d;
                end
                HOLD_I: w_sel_i = 1'b1;
                HOLD_D: w_sel_d = 1'b1;
                WAIT_I: begin
                    if (bus.m_rvalid) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.m_rdata;
                        w_next       = IDLE;
                    end
                end
                WAIT_D: begin
                    if (bus.m_rvalid) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.m_rdata;
                        w_next       = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end

        if (w_sel_d) begin
            bus.m_req   = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_size  = bus.d_size;
            bus.m_wdata = bus.d_wdata;
            bus.d_gnt   = bus.m_ready;
            w_next      = bus.m_ready ? WAIT_D : HOLD_D;
        end else if (w_sel_i) begin
            bus.m_req   = 1'b1;
            bus.m_addr  = bus.i_addr;
            bus.m_size  = 2'd2;
            bus.i_gnt   = bus.m_ready;
            w_next      = bus.m_ready ? WAIT_I : HOLD_I;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    mem_arbiter #(
        .AWIDTH(32),
        .DWIDTH(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who is waiting for a response, who is locked, starvation count.
    int pend  = 0;  // 0 none, 1 fetch, 2 mem-stage
    int lockd = 0;
    int starve = 0;

    always @(negedge clk) begin
        int          win;
        logic        e_req, e_we, e_ig, e_dg, e_irv, e_drv;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic [1:0]  e_sz;
        win = 0;
        if (!reset && pend == 0) begin
            if (lockd != 0) win = lockd;
            else if (bus.d_req && !(FAIR && starve >= LIMIT && bus.i_req)) win = 2;
            else if (bus.i_req) win = 1;
        end
        e_req  = (win != 0);
        e_we   = (win == 2) ? bus.d_we : 1'b0;
        e_addr = (win == 2) ? bus.d_addr : (win == 1) ? bus.i_addr : 32'h0;
        e_sz   = (win == 2) ? bus.d_size : (win == 1) ? 2'd2 : 2'd0;
        e_wd   = (win == 2) ? bus.d_wdata : 32'h0;
        e_ig   = (win == 1) && bus.m_ready;
        e_dg   = (win == 2) && bus.m_ready;
        e_irv  = !reset && pend == 1 && bus.m_rvalid;
        e_drv  = !reset && pend == 2 && bus.m_rvalid;
        e_ird  = e_irv ? bus.m_rdata : 32'h0;
        e_drd  = e_drv ? bus.m_rdata : 32'h0;

        chk("m_req", bus.m_req, e_req);
        chk("m_we", bus.m_we, e_we);
        chk("m_addr", bus.m_addr, e_addr);
        chk("m_size", bus.m_size, e_sz);
        chk("m_wdata", bus.m_wdata, e_wd);
        chk("i_gnt", bus.i_gnt, e_ig);
        chk("d_gnt", bus.d_gnt, e_dg);
        chk("i_rvalid", bus.i_rvalid, e_irv);
        chk("d_rvalid", bus.d_rvalid, e_drv);
        chk("i_rdata", bus.i_rdata, e_ird);
        chk("d_rdata", bus.d_rdata, e_drd);

        if (reset) begin
            pend = 0; lockd = 0; starve = 0;
        end else begin
            if (e_irv || e_drv) pend = 0;
            else if (win != 0 && bus.m_ready) begin pend = win; lockd = 0; end
            else if (win != 0) lockd = win;
            if (e_ig) starve = 0;
            else if (bus.i_req && starve < LIMIT) starve++;
        end
    end

    task automatic step(input logic rs, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [1:0] ds, input logic [31:0] dwd,
                        input logic mr, input logic mv, input logic [31:0] md);
        @(posedge clk);
        #1;
        reset        = rs;
        bus.i_req    = ir;
        bus.i_addr   = ia;
        bus.d_req    = dr;
        bus.d_we     = dw;
        bus.d_addr   = da;
        bus.d_size   = ds;
        bus.d_wdata  = dwd;
        bus.m_ready  = mr;
        bus.m_rvalid = mv;
        bus.m_rdata  = md;
        #2;
    endtask

    localparam logic [31:0] IA = 32'h0100_0000;
    localparam logic [31:0] DA = 32'h0100_0100;

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_size = 0; bus.d_wdata = 0;
        bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = 0;

        // Reset state, requests present but masked
        step(1, 1, IA, 1, 0, DA, 2, 0, 1, 1, 32'h1234);
        chk("rst_mreq", bus.m_req, 0);
        chk("rst_dgnt", bus.d_gnt, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch only
        step(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("f_igent", bus.i_gnt, 1);
        chk("f_msize", bus.m_size, 2);
        chk("f_maddr", bus.m_addr, IA);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
        chk("f_irv", bus.i_rvalid, 1);
        chk("f_ird", bus.i_rdata, 32'h0000_0013);
        chk("f_mreq", bus.m_req, 0);

        // Simultaneous: store wins, fetch two cycles later
        step(0, 1, IA, 1, 1, DA, 2, 32'hDEAD_BEEF, 1, 0, 0);
        chk("s_dgnt", bus.d_gnt, 1);
        chk("s_igent", bus.i_gnt, 0);
        chk("s_mwe", bus.m_we, 1);
        chk("s_mwd", bus.m_wdata, 32'hDEAD_BEEF);
        step(0, 1, IA, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("s_drv", bus.d_rvalid, 1);
        chk("s_noarb", bus.i_gnt, 0);
        step(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("s_igent", bus.i_gnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);

        // Backpressure: memory-stage held, fetch arrives meanwhile
        step(0, 0, 0, 1, 0, DA, 2, 0, 0, 0, 0);
        chk("b_maddr0", bus.m_addr, DA);
        step(0, 1, IA, 1, 0, DA, 2, 0, 0, 0, 0);
        chk("b_maddr1", bus.m_addr, DA);
        chk("b_ig1", bus.i_gnt, 0);
        step(0, 1, IA, 1, 0, DA, 2, 0, 0, 0, 0);
        step(0, 1, IA, 1, 0, DA, 2, 0, 1, 0, 0);
        chk("b_dgnt", bus.d_gnt, 1);
        chk("b_ig3", bus.i_gnt, 0);
        step(0, 1, IA, 0, 0, 0, 0, 0, 1, 1, 32'h5555_AAAA);
        step(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("b_igent", bus.i_gnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_0000);

        // m_rvalid while holding is ignored
        step(0, 0, 0, 1, 0, DA, 1, 0, 0, 1, 32'hFFFF_FFFF);
        chk("h_drv", bus.d_rvalid, 0);
        chk("h_drd", bus.d_rdata, 0);
        step(0, 0, 0, 1, 0, DA, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_BEEF);

        // Byte load
        step(0, 0, 0, 1, 0, DA + 3, 0, 0, 1, 0, 0);
        chk("l_msize", bus.m_size, 0);
        chk("l_mwe", bus.m_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_5A81);
        chk("l_drd", bus.d_rdata, 32'hA5A5_5A81);

        // Starvation: both requests held, memory always ready/responding
        for (int k = 0; k < 8; k++) begin
            step(0, 1, IA, 1, 0, DA, 2, 0, 1, 1, 32'h100 + k);
            chk("st_igent", bus.i_gnt, (FAIR && k == 4));
        end

        // Reset while waiting on a load, then a late response
        step(0, 0, 0, 1, 0, DA, 2, 0, 1, 0, 0);
        chk("r_dgnt", bus.d_gnt, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r_mreq", bus.m_req, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        chk("r_drv", bus.d_rvalid, 0);
        chk("r_irv", bus.i_rvalid, 0);
        chk("r_mreq2", bus.m_req, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
